// File: rtl/ftoi_pipe.sv
// IEEE-754 single to signed 32-bit integer converter with valid/ready pipeline.
// Optional FTOI_FLOOR_EN adds the rm port (rm=1 rounds toward -inf).
module ftoi_pipe #(
    parameter int NSTAGE = 2
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] x,
`ifdef FTOI_FLOOR_EN
    input  logic        rm,
`endif
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] y,
    output logic        ovf
);

    typedef struct packed {
        logic        sgn;
        logic [31:0] mag;
        logic        inc;
        logic        zero;
        logic        sat;
        logic        minint;
    } s1_t;

    logic        rm_s;
    logic        out_valid_r;
    logic [31:0] y_r;
    logic        ovf_r;

`ifdef FTOI_FLOOR_EN
    assign rm_s = rm;
`else
    assign rm_s = 1'b0;
`endif

    assign out_valid = out_valid_r;
    assign y         = y_r;
    assign ovf       = ovf_r;

    // Classify the operand and denormalise it; inc is the increment to apply after the shift.
    function automatic s1_t unpack_word(input logic [31:0] w, input logic floor_md);
        s1_t        r;
        logic [7:0]  e;
        logic [23:0] m;
        logic [7:0]  sh;
        logic [47:0] ext;
        e        = w[30:23];
        m        = {1'b1, w[22:0]};
        sh       = 8'd150 - e;
        ext      = {m, 24'd0} >> sh;
        r.sgn    = w[31];
        r.mag    = 32'd0;
        r.inc    = 1'b0;
        r.zero   = 1'b0;
        r.sat    = 1'b0;
        r.minint = 1'b0;
        if (e == 8'd0) begin
            r.zero = 1'b1;
        end else if (e <= 8'd125) begin
            // Below one half: only a negative value under floor mode moves away from zero.
            if (floor_md && w[31]) begin
                r.inc = 1'b1;
            end else begin
                r.zero = 1'b1;
            end
        end else if (e <= 8'd149) begin
            r.mag = {8'd0, ext[47:24]};
            if (floor_md) begin
                r.inc = w[31] & (|ext[23:0]);
            end else begin
                r.inc = ext[23];
            end
        end else if (e <= 8'd157) begin
            r.mag = {8'd0, m} << (e - 8'd150);
        end else if (w[31] && (e == 8'd158) && (w[22:0] == 23'd0)) begin
            r.minint = 1'b1;
        end else begin
            r.sat = 1'b1;
        end
        return r;
    endfunction

    // Apply rounding increment and sign; returns {ovf, y}.
    function automatic logic [32:0] round_pack(input s1_t r);
        logic [31:0] mag;
        logic [32:0] res;
        mag = r.mag + {31'd0, r.inc};
        if (r.zero) begin
            res = {1'b0, 32'd0};
        end else if (r.sat) begin
            res = {1'b1, (r.sgn ? 32'h8000_0000 : 32'h7FFF_FFFF)};
        end else if (r.minint) begin
            res = {1'b0, 32'h8000_0000};
        end else if (r.sgn) begin
            res = {1'b0, (~mag + 32'd1)};
        end else begin
            res = {1'b0, mag};
        end
        return res;
    endfunction

    generate
        if (NSTAGE == 2) begin : g_two
            s1_t  s1_r;
            logic s1_valid_r;
            logic s2_free_s;
            logic s1_adv_s;

            assign s2_free_s = ~out_valid_r | out_ready;
            assign s1_adv_s  = s1_valid_r & s2_free_s;
            assign in_ready  = ~s1_valid_r | s1_adv_s;

            // Unpack stage: loads whenever it is empty or handing its word on.
            always_ff @(posedge clk or negedge rstn) begin
                if (!rstn) begin
                    s1_valid_r <= 1'b0;
                    s1_r       <= '0;
                end else if (in_ready) begin
                    s1_valid_r <= in_valid;
                    if (in_valid) begin
                        s1_r <= unpack_word(x, rm_s);
                    end
                end
            end

            // Round/pack stage drives the registered outputs.
            always_ff @(posedge clk or negedge rstn) begin
                if (!rstn) begin
                    out_valid_r <= 1'b0;
                    y_r         <= 32'd0;
                    ovf_r       <= 1'b0;
                end else if (s2_free_s) begin
                    out_valid_r <= s1_valid_r;
                    if (s1_valid_r) begin
                        {ovf_r, y_r} <= round_pack(s1_r);
                    end
                end
            end
        end else begin : g_one
            assign in_ready = ~out_valid_r | out_ready;

            // Single stage: full conversion between input and output register.
            always_ff @(posedge clk or negedge rstn) begin
                if (!rstn) begin
                    out_valid_r <= 1'b0;
                    y_r         <= 32'd0;
                    ovf_r       <= 1'b0;
                end else if (in_ready) begin
                    out_valid_r <= in_valid;
                    if (in_valid) begin
                        {ovf_r, y_r} <= round_pack(unpack_word(x, rm_s));
                    end
                end
            end
        end
    endgenerate

endmodule

// File: tb/tb_ftoi_pipe.sv
// Self-checking bench for ftoi_pipe: real-arithmetic reference model plus directed vectors.
module tb_ftoi_pipe;

    localparam int NSTAGE = 2;

    logic        clk = 1'b0;
    logic        rstn;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] x;
    logic        rm_v;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] y;
    logic        ovf;

    int n_checks = 0;
    int n_fail   = 0;

    logic [32:0] exp_q[$];
    logic        hold_pending = 1'b0;
    logic [31:0] hold_y;
    logic        hold_o;

    always #5 clk = ~clk;

    ftoi_pipe #(.NSTAGE(NSTAGE)) dut (
        .clk       (clk),
        .rstn      (rstn),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .x         (x),
`ifdef FTOI_FLOOR_EN
        .rm        (rm_v),
`endif
        .out_valid (out_valid),
        .out_ready (out_ready),
        .y         (y),
        .ovf       (ovf)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endtask

    // Reference: value of the float as a real, rounded, then range-checked. Returns {ovf, y}.
    function automatic logic [32:0] model(input logic [31:0] w, input logic r);
        int  e;
        real v;
        real q;
        e = int'(w[30:23]);
        if (e == 0) return {1'b0, 32'h0000_0000};
        if (e == 255) return {1'b1, (w[31] ? 32'h8000_0000 : 32'h7FFF_FFFF)};
        v = (1.0 + real'(w[22:0]) / 8388608.0) * (2.0 ** (real'(e) - 127.0));
        if (w[31]) v = -v;
        if (r) q = $floor(v);
        else if (v < 0.0) q = -$floor(-v + 0.5);
        else q = $floor(v + 0.5);
        if (q > 2147483647.0 || q < -2147483648.0)
            return {1'b1, (w[31] ? 32'h8000_0000 : 32'h7FFF_FFFF)};
        return {1'b0, 32'(longint'(q))};
    endfunction

    // Compare process: scoreboard, stall stability and in_ready occupancy rule.
    always @(negedge clk) begin
        logic [32:0] e;
        if (rstn) begin
            if (hold_pending) begin
                chk("hold_valid", {31'd0, out_valid}, 32'd1);
                chk("hold_y", y, hold_y);
                chk("hold_ovf", {31'd0, ovf}, {31'd0, hold_o});
            end
            hold_pending = out_valid & ~out_ready;
            hold_y = y;
            hold_o = ovf;
            chk("in_ready", {31'd0, in_ready},
                {31'd0, ~((exp_q.size() >= NSTAGE) & ~out_ready)});
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    chk("spurious_out", 32'd1, 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    chk("y", y, e[31:0]);
                    chk("ovf", {31'd0, ovf}, {31'd0, e[32]});
                end
            end
            if (in_valid && in_ready) exp_q.push_back(model(x, rm_v));
        end
    end

    // One word through an empty pipe: latency and hand-computed result.
    task automatic send_one(input logic [31:0] w, input logic r, input logic [31:0] ey,
                            input logic eo, input string nm);
        int lat;
        @(posedge clk); #2;
        in_valid = 1'b1; x = w; rm_v = r; out_ready = 1'b1;
        @(posedge clk); #2;
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 20) begin
            @(posedge clk); #2;
            lat++;
        end
        chk({nm, "_lat"}, lat, NSTAGE);
        chk({nm, "_y"}, y, ey);
        chk({nm, "_ovf"}, {31'd0, ovf}, {31'd0, eo});
    endtask

    task automatic drain();
        int n;
        @(posedge clk); #2;
        in_valid = 1'b0; out_ready = 1'b1;
        n = 0;
        while (exp_q.size() != 0 && n < 50) begin
            @(posedge clk); #2;
            n++;
        end
        chk("drain_empty", exp_q.size(), 32'd0);
    endtask

    initial begin
        logic [32:0] mres;
        logic [31:0] burst[16];
        logic [4:0]  pat;
        int          idx;
        int          cyc;

        rstn = 1'b0; in_valid = 1'b0; x = 32'd0; rm_v = 1'b0; out_ready = 1'b0;
        #1;
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_y", y, 32'd0);
        chk("rst_ovf", {31'd0, ovf}, 32'd0);

        // Pin the reference model against hand-computed values.
        mres = model(32'h3FC0_0000, 1'b0); chk("model_1p5", mres[31:0], 32'd2);
        mres = model(32'hBFC0_0000, 1'b0); chk("model_m1p5", mres[31:0], 32'hFFFF_FFFE);
        mres = model(32'h3F00_0000, 1'b0); chk("model_half", mres[31:0], 32'd1);
        mres = model(32'hCF00_0000, 1'b0); chk("model_minint", mres, {1'b0, 32'h8000_0000});
        mres = model(32'h4F00_0000, 1'b0); chk("model_sat", mres, {1'b1, 32'h7FFF_FFFF});

        #20;
        @(posedge clk); #2;
        rstn = 1'b1;

        send_one(32'h3FC0_0000, 1'b0, 32'd2, 1'b0, "p1_5");
        send_one(32'hBFC0_0000, 1'b0, 32'hFFFF_FFFE, 1'b0, "m1_5");
        send_one(32'h3EFF_FFFF, 1'b0, 32'd0, 1'b0, "below_half");
        send_one(32'h3F00_0000, 1'b0, 32'd1, 1'b0, "half");
        send_one(32'h0000_0001, 1'b0, 32'd0, 1'b0, "subnormal");
        send_one(32'h8000_0000, 1'b0, 32'd0, 1'b0, "neg_zero");
        send_one(32'h4F00_0000, 1'b0, 32'h7FFF_FFFF, 1'b1, "pos_2p31");
        send_one(32'hCF00_0000, 1'b0, 32'h8000_0000, 1'b0, "minint");
        send_one(32'hCF00_0001, 1'b0, 32'h8000_0000, 1'b1, "below_minint");
        send_one(32'h7FC0_0000, 1'b0, 32'h7FFF_FFFF, 1'b1, "nan");
        send_one(32'hFF80_0000, 1'b0, 32'h8000_0000, 1'b1, "neg_inf");
        send_one(32'h4EFF_FFFF, 1'b0, 32'h7FFF_FF80, 1'b0, "max_exact");
        send_one(32'h4B00_0001, 1'b0, 32'h0080_0001, 1'b0, "e150");
        send_one(32'h4AFF_FFFF, 1'b0, 32'h0080_0000, 1'b0, "e149_round");
        drain();

        // Back-to-back burst under a stalling consumer.
        burst = '{32'h3F80_0000, 32'h4020_0000, 32'hC020_0000, 32'h42C8_0000,
                  32'h3FC0_0000, 32'hBF00_0000, 32'h4E6E_6B28, 32'hCE6E_6B28,
                  32'h7F80_0000, 32'h3E80_0000, 32'h4B7F_FFFF, 32'h4B00_0000,
                  32'hC47A_1000, 32'h4F00_0000, 32'h0000_0000, 32'h4049_0FDB};
        pat = 5'b01101;
        idx = 0;
        cyc = 0;
        while (idx < 16 && cyc < 200) begin
            @(posedge clk); #2;
            in_valid = 1'b1; x = burst[idx]; rm_v = 1'b0; out_ready = pat[cyc % 5];
            cyc++;
            #1;
            if (in_ready) idx++;
        end
        chk("burst_accepted", idx, 32'd16);
        drain();

        // Reset with two words in flight.
        @(posedge clk); #2;
        out_ready = 1'b0; in_valid = 1'b1; x = 32'h4120_0000;
        @(posedge clk); #2;
        x = 32'h4140_0000;
        @(posedge clk); #2;
        in_valid = 1'b0;
        #1;
        rstn = 1'b0;
        #1;
        chk("midrst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("midrst_y", y, 32'd0);
        chk("midrst_ovf", {31'd0, ovf}, 32'd0);
        exp_q.delete();
        hold_pending = 1'b0;
        @(posedge clk); #2;
        rstn = 1'b1;
        send_one(32'h4160_0000, 1'b0, 32'd14, 1'b0, "after_rst");
        drain();

`ifdef FTOI_FLOOR_EN
        send_one(32'hBFC0_0000, 1'b1, 32'hFFFF_FFFE, 1'b0, "floor_m1_5");
        send_one(32'h3FC0_0000, 1'b1, 32'd1, 1'b0, "floor_p1_5");
        send_one(32'hBE80_0000, 1'b1, 32'hFFFF_FFFF, 1'b0, "floor_m0_25");
        send_one(32'h3E80_0000, 1'b1, 32'd0, 1'b0, "floor_p0_25");
        send_one(32'hC000_0000, 1'b1, 32'hFFFF_FFFE, 1'b0, "floor_m2");
        drain();
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
